// File: rtl/sram_ctrl_pkg.sv
// Shared constants for the 1rw SRAM request controller: FSM state codes and
// credit counter sizing.
package sram_ctrl_pkg;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Width able to hold every value 0..depth of the response credit pool.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl_rsp_fifo.sv
// Response FIFO for sram_1rw_req_ctrl; head_data reads as zero when empty.
module sram_ctrl_rsp_fifo
  import sram_ctrl_pkg::*;
#(
  parameter int BITS      = 96,
  parameter int RSP_DEPTH = 2,
  localparam int CW       = credit_width(RSP_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [BITS-1:0] push_data,
  input  logic            pop,
  output logic [BITS-1:0] head_data,
  output logic [CW-1:0]   count
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(RSP_DEPTH);

  logic [BITS-1:0] r_mem [RSP_DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_do_push;
  logic            w_do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == LAST_PTR) ? {PW{1'b0}} : ptr + {{(PW-1){1'b0}}, 1'b1};
  endfunction

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  always_comb begin
    w_do_pop  = pop && (r_count != {CW{1'b0}});
    w_do_push = push && ((r_count != FULL_CNT) || w_do_pop);
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
    end else begin
      if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   r_count <= r_count - {{(CW-1){1'b0}}, 1'b1};
        default: r_count <= r_count;
      endcase
    end
  end

  // Data storage carries no reset; validity comes from r_count alone.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

  // Head presentation, forced to zero when nothing is stored.
  always_comb begin
    if (r_count == {CW{1'b0}}) head_data = {BITS{1'b0}};
    else                       head_data = r_mem[r_rd_ptr];
  end

  assign count = r_count;

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Valid/ready request front-end for a 1rw SRAM macro with credit-protected read
// responses. Define SRAM_CTRL_INIT_EN to zero-fill the whole array after reset.
module sram_1rw_req_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BITS       = 96,
  parameter int WORD_DEPTH = 4096,
  parameter int ADDR_WIDTH = 12,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_in,
  output logic                  req_ready_out,
  input  logic [ADDR_WIDTH-1:0] req_addr_in,
  input  logic                  req_we_in,
  input  logic [BITS-1:0]       req_wd_in,
  input  logic [BITS-1:0]       req_w_mask_in,
  output logic                  rsp_valid_out,
  input  logic                  rsp_ready_in,
  output logic [BITS-1:0]       rsp_data_out,
  output logic                  sram_ce_out,
  output logic                  sram_we_out,
  output logic [ADDR_WIDTH-1:0] sram_addr_out,
  output logic [BITS-1:0]       sram_wd_out,
  output logic [BITS-1:0]       sram_w_mask_out,
  input  logic [BITS-1:0]       sram_rd_in,
  output logic                  busy_out
);

  localparam int CW = credit_width(RSP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RSP_DEPTH);

  logic [0:0]            r_state;
  logic                  r_rd_inflight;
  logic [CW-1:0]         w_fifo_count;
  logic [CW-1:0]         w_used;
  logic [BITS-1:0]       w_head;
  logic                  w_accept;
  logic                  w_fifo_pop;
  logic                  w_init_active;
  logic [ADDR_WIDTH-1:0] w_init_addr;

`ifdef SRAM_CTRL_INIT_EN
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORD_DEPTH - 1);
  logic [ADDR_WIDTH-1:0] r_init_addr;

  // Zero-fill sweep: one word per cycle, RUN follows the last address.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_INIT;
      r_init_addr <= {ADDR_WIDTH{1'b0}};
    end else if (r_state == ST_INIT) begin
      if (r_init_addr == LAST_ADDR) begin
        r_state     <= ST_RUN;
        r_init_addr <= {ADDR_WIDTH{1'b0}};
      end else begin
        r_state     <= ST_INIT;
        r_init_addr <= r_init_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
      end
    end else begin
      r_state     <= r_state;
      r_init_addr <= r_init_addr;
    end
  end

  assign w_init_addr = r_init_addr;
  assign busy_out    = rst || (r_state == ST_INIT);
`else
  // Without the sweep the controller is always in RUN.
  always_ff @(posedge clk) begin
    r_state <= ST_RUN;
  end

  assign w_init_addr = {ADDR_WIDTH{1'b0}};
  assign busy_out    = 1'b0;
`endif

  // Reads need a free slot counting both queued data and the read at the macro.
  always_comb begin
    w_used        = w_fifo_count + CW'(r_rd_inflight);
    w_init_active = !rst && (r_state == ST_INIT);
    req_ready_out = !rst && (r_state == ST_RUN) && (req_we_in || (w_used < DEPTH_C));
    w_accept      = req_valid_in && req_ready_out;
  end

  // SRAM pins are driven to zero whenever no access is issued.
  always_comb begin
    sram_ce_out     = 1'b0;
    sram_we_out     = 1'b0;
    sram_addr_out   = {ADDR_WIDTH{1'b0}};
    sram_wd_out     = {BITS{1'b0}};
    sram_w_mask_out = {BITS{1'b0}};
    if (w_accept) begin
      sram_ce_out     = 1'b1;
      sram_we_out     = req_we_in;
      sram_addr_out   = req_addr_in;
      sram_wd_out     = req_wd_in;
      sram_w_mask_out = req_w_mask_in;
    end else if (w_init_active) begin
      sram_ce_out     = 1'b1;
      sram_we_out     = 1'b1;
      sram_addr_out   = w_init_addr;
      sram_wd_out     = {BITS{1'b0}};
      sram_w_mask_out = {BITS{1'b1}};
    end else begin
      sram_ce_out     = 1'b0;
    end
  end

  // Marks the cycle in which the macro presents read data.
  always_ff @(posedge clk) begin
    if (rst) r_rd_inflight <= 1'b0;
    else     r_rd_inflight <= w_accept && !req_we_in;
  end

  sram_ctrl_rsp_fifo #(
    .BITS      (BITS),
    .RSP_DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_rd_inflight),
    .push_data (sram_rd_in),
    .pop       (w_fifo_pop),
    .head_data (w_head),
    .count     (w_fifo_count)
  );

  // Response side is held quiet during reset.
  always_comb begin
    rsp_valid_out = !rst && (w_fifo_count != {CW{1'b0}});
    w_fifo_pop    = rsp_valid_out && rsp_ready_in;
    if (rst) rsp_data_out = {BITS{1'b0}};
    else     rsp_data_out = w_head;
  end

endmodule
